uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 / 19200-baud transmitter. Adds configurable baud divisor, data width, parity mode and stop-bit count. A small transmit FIFO allows back-to-back frames with no idle gap between them. Sits between the SNN result/host-side logic and the board TX pin, on the single 50 MHz system clock.

Parameters:
BAUD_DIV, 2604, clk cycles per bit period (2604 = 19200 baud at 50 MHz); legal range 2..4095.
DATA_BITS, 8, payload bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
FIFO_DEPTH, 4, transmit FIFO entries; power of two, at least 2.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-high
tx_start  in  1  write strobe; data is accepted on a rising edge where tx_start && tx_rdy
tx_data  in  DATA_BITS  payload; sampled only on the accepting edge
tx_rdy  out  1  FIFO not full
tx  out  1  serial line; idle high
tx_busy  out  1  high while a frame is on the line (FSM not IDLE)
tx_done  out  1  one-cycle pulse when the final stop bit of a frame completes
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, takes effect immediately): tx=1, tx_busy=0, tx_done=0, tx_rdy=1, fifo_cnt=0, FSM=IDLE. The FIFO is emptied and the baud and bit counters are cleared.
- Reset during a frame aborts it; the line returns high at once and no partial frame resumes.
- FIFO write: occurs on an edge with tx_start && tx_rdy.
- FIFO full: tx_start while full is ignored, even if a pop happens on the same edge.
- FIFO simultaneous write and pop: occupancy is unchanged.
- Frame format, LSB first: start(0), DATA_BITS payload bits, optional parity bit, STOP_BITS stop bits(1). Each bit lasts exactly BAUD_DIV cycles.
- Parity: even parity = XOR of the payload bits; odd parity = its inverse.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE -> START: when the FIFO is non-empty. On that edge the entry is popped, the shift register is loaded, and the baud counter is cleared.
- START -> DATA: after BAUD_DIV cycles.
- DATA -> PAR: after DATA_BITS bits, when PARITY != 0.
- DATA -> STOP: after DATA_BITS bits, when PARITY == 0.
- PAR -> STOP: after one bit period.
- STOP end: after STOP_BITS bit periods, tx_done pulses on that edge. If the FIFO is non-empty, pop on the same edge and go to START (zero gap); otherwise go to IDLE.
- Latency: with an empty FIFO, a word accepted at edge E0 is popped at E1, and tx is low from E1 for BAUD_DIV cycles.
- tx is driven from the FSM state and shift register bit 0. There is no combinational path from the inputs to tx.
- Frame length: BAUD_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- Baud counter: 12-bit, wraps at BAUD_DIV-1.
- Bit counter: 4-bit, cleared on each state change.
- tx_data sampled on the accepting edge may change freely afterwards.

Decomposition:
- Shared package uart_pkg holds:
  - parity_t enum: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - tx_state_t enum: IDLE, START, DATA, PAR, STOP.
  - BAUD_19200_50M=2604.
- One sub-module uart_fifo: synchronous FIFO with parametrised width and depth.
  - Inputs: wr_en, wr_data, rd_en.
  - Outputs: rd_data (first-word-fall-through), full, empty, count.
  - Reset: the same asynchronous active-high rst.

Test Plan:
- Defaults, write 0xA5 once -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 2604 cycles; tx_done pulses exactly 26040 cycles after the pop edge; tx_busy falls on the same edge.
- DATA_BITS=7, PARITY=1, BAUD_DIV=4, write 0x55 -> payload 1,0,1,0,1,0,1, parity 0, one stop; frame is 40 cycles. With PARITY=2 the parity bit is 1.
- BAUD_DIV=4, FIFO_DEPTH=4, tx_start held for 6 consecutive cycles with data 1..6 -> words 1..5 accepted; tx_rdy low on the 6th edge; fifo_cnt peaks at 4. Five frames are sent back-to-back with no high gap between stop and start; tx_done pulses 5 times, 40 cycles apart.
- STOP_BITS=2, BAUD_DIV=4, write 0xFF -> 11-bit frame of 44 cycles; tx high for the final 8 cycles before tx_done.
- BAUD_DIV=4, assert rst asynchronously mid DATA bit 3 -> tx=1, tx_busy=0, fifo_cnt=0, tx_rdy=1 before the next clock edge. After release, a new write of 0x3C produces a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam int unsigned BAUD_19200_50M = 2604;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty/count.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;
  logic [CW-1:0]    count_nxt;

  // A write while full is dropped even if a pop happens on the same edge.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd)
      count_nxt = count + CW'(1);
    else if (!do_wr && do_rd)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-fed framer with configurable baud, width,
// parity and stop bits; frames queued in the FIFO go out with no idle gap.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = BAUD_19200_50M,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_start,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_rdy,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam parity_t PMODE = parity_t'(2'(PARITY));

  tx_state_t            state;
  logic [11:0]          baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 pop;
  logic                 baud_end;
  logic                 last_data;
  logic                 last_stop;

  assign tx_rdy    = !fifo_full;
  assign baud_end  = (baud_cnt == 12'(BAUD_DIV - 1));
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
  // Pop when idle, or at the end of the last stop bit for a zero-gap follow-on.
  assign pop = !fifo_empty &&
               ((state == IDLE) || (state == STOP && baud_end && last_stop));

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_start && tx_rdy),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE)
        baud_cnt <= baud_end ? 12'd0 : baud_cnt + 12'd1;

      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            shreg    <= fifo_data;
            par_bit  <= (^fifo_data) ^ (PMODE == PAR_ODD);
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx      <= shreg[0];
          end
        end
        DATA: begin
          if (baud_end) begin
            if (last_data) begin
              bit_cnt <= '0;
              if (PMODE != PAR_NONE) begin
                state <= PAR;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PAR: begin
          if (baud_end) begin
            state   <= STOP;
            bit_cnt <= '0;
            tx      <= 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            if (last_stop) begin
              tx_done <= 1'b1;
              bit_cnt <= '0;
              if (pop) begin
                state   <= START;
                shreg   <= fifo_data;
                par_bit <= (^fifo_data) ^ (PMODE == PAR_ODD);
                tx      <= 1'b0;
              end else begin
                state   <= IDLE;
                tx      <= 1'b1;
                tx_busy <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five differently configured instances, each checked
// cycle-by-cycle against a frame model built from the framing rules.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [5];
  logic [8:0] dat   [5];
  logic       tx_w  [5];
  logic       busy_w[5];
  logic       done_w[5];
  logic       rdy_w [5];
  logic [2:0] cnt_w [5];

  int errors = 0;
  int checks = 0;

  logic        rec_tx[$];
  logic        rec_done[$];
  logic        rec_busy[$];
  int unsigned exp_words[$];

  always #5 clk = ~clk;

  uart_tx_param u0 (
    .clk(clk), .rst(rst), .tx_start(start[0]), .tx_data(dat[0][7:0]),
    .tx_rdy(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]),
    .fifo_cnt(cnt_w[0]));

  uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .tx_start(start[1]), .tx_data(dat[1][6:0]),
    .tx_rdy(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]),
    .fifo_cnt(cnt_w[1]));

  uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .tx_start(start[2]), .tx_data(dat[2][6:0]),
    .tx_rdy(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]),
    .fifo_cnt(cnt_w[2]));

  uart_tx_param #(.BAUD_DIV(4), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_start(start[3]), .tx_data(dat[3][7:0]),
    .tx_rdy(rdy_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]),
    .fifo_cnt(cnt_w[3]));

  uart_tx_param #(.BAUD_DIV(4)) u4 (
    .clk(clk), .rst(rst), .tx_start(start[4]), .tx_data(dat[4][7:0]),
    .tx_rdy(rdy_w[4]), .tx(tx_w[4]), .tx_busy(busy_w[4]), .tx_done(done_w[4]),
    .fifo_cnt(cnt_w[4]));

  // Reference frame: bit c of the frame on the line, LSB-first payload.
  function automatic logic [15:0] frame_vec(input int unsigned data, input int dbits,
                                            input int par);
    logic [15:0] v;
    int ones;
    v    = '1;
    v[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < dbits; i++) begin
      v[1+i] = ((data >> i) & 1) != 0;
      ones  += int'((data >> i) & 1);
    end
    if (par != 0) v[1+dbits] = (par == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
    return v;
  endfunction

  function automatic int frame_bits(input int dbits, input int par, input int stops);
    return 1 + dbits + ((par != 0) ? 1 : 0) + stops;
  endfunction

  // Number of recorded cycles whose tx differs from the model line waveform.
  function automatic int wave_errs(input int bd, input int dbits, input int par,
                                   input int stops, input int s);
    int len, nf, e, rel;
    logic [15:0] v;
    logic exp_bit;
    len = frame_bits(dbits, par, stops) * bd;
    nf  = exp_words.size();
    e   = 0;
    for (int j = 0; j < rec_tx.size(); j++) begin
      rel = j - s;
      if (rel < 0 || rel >= nf * len) begin
        exp_bit = 1'b1;
      end else begin
        v       = frame_vec(exp_words[rel / len], dbits, par);
        exp_bit = v[(rel % len) / bd];
      end
      if (rec_tx[j] !== exp_bit) e++;
    end
    return e;
  endfunction

  function automatic int done_total();
    int n = 0;
    for (int j = 0; j < rec_done.size(); j++)
      if (rec_done[j] === 1'b1) n++;
    return n;
  endfunction

  task automatic record(input int k, input int n);
    rec_tx.delete();
    rec_done.delete();
    rec_busy.delete();
    repeat (n) begin
      rec_tx.push_back(tx_w[k]);
      rec_done.push_back(done_w[k]);
      rec_busy.push_back(busy_w[k]);
      @(negedge clk);
    end
  endtask

  task automatic drive_words(input int k);
    for (int i = 0; i < exp_words.size(); i++) begin
      start[k] = 1'b1;
      dat[k]   = 9'(exp_words[i]);
      @(negedge clk);
    end
    start[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++; if (tx_w[k] !== 1'b1) begin errors++; $display("FAIL reset_tx[%0d]: got %b expected 1", k, tx_w[k]); end
      checks++; if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy_w[k]); end
      checks++; if (done_w[k] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b expected 0", k, done_w[k]); end
      checks++; if (rdy_w[k] !== 1'b1) begin errors++; $display("FAIL reset_rdy[%0d]: got %b expected 1", k, rdy_w[k]); end
      checks++; if (cnt_w[k] !== 3'd0) begin errors++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", k, cnt_w[k]); end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy_w[4] !== 1'b0 || tx_w[4] !== 1'b1) begin errors++; $display("FAIL post_reset_idle: busy=%b tx=%b expected 0/1", busy_w[4], tx_w[4]); end
  endtask

  task automatic test_default();
    logic [9:0] spec_seq;
    int e;
    spec_seq = 10'b1101001010;
    exp_words.delete();
    exp_words.push_back(32'hA5);
    fork
      drive_words(0);
      record(0, 2 + 26040 + 4);
    join
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rec_tx[2 + c*2604 + 1302] !== spec_seq[c]) begin
        errors++; $display("FAIL a5_bit%0d: got %b expected %b", c, rec_tx[2 + c*2604 + 1302], spec_seq[c]);
      end
    end
    e = wave_errs(2604, 8, 0, 1, 2);
    checks++; if (e !== 0) begin errors++; $display("FAIL a5_wave: %0d cycles differ, expected 0", e); end
    checks++; if (rec_done[2 + 26040] !== 1'b1) begin errors++; $display("FAIL a5_done_edge: got %b expected 1", rec_done[2 + 26040]); end
    checks++; if (done_total() !== 1) begin errors++; $display("FAIL a5_done_count: got %0d expected 1", done_total()); end
    checks++; if (rec_busy[2 + 26039] !== 1'b1 || rec_busy[2 + 26040] !== 1'b0) begin
      errors++; $display("FAIL a5_busy_fall: got %b%b expected 10", rec_busy[2 + 26039], rec_busy[2 + 26040]);
    end
  endtask

  task automatic test_parity();
    int e;
    int unsigned w;
    for (int k = 1; k <= 2; k++) begin
      for (int r = 0; r < 3; r++) begin
        w = (r == 0) ? 32'h55 : $urandom_range(0, 127);
        exp_words.delete();
        exp_words.push_back(w);
        fork
          drive_words(k);
          record(k, 2 + 40 + 4);
        join
        e = wave_errs(4, 7, k, 1, 2);
        checks++; if (e !== 0) begin errors++; $display("FAIL par%0d_wave w=%0h: %0d cycles differ, expected 0", k, w, e); end
        checks++; if (rec_done[2 + 40] !== 1'b1 || done_total() !== 1) begin
          errors++; $display("FAIL par%0d_done w=%0h: at40=%b count=%0d expected 1/1", k, w, rec_done[2 + 40], done_total());
        end
        if (r == 0) begin
          checks++;
          if (rec_tx[2 + 8*4 + 2] !== 1'(k == 2)) begin
            errors++; $display("FAIL par%0d_bit55: got %b expected %b", k, rec_tx[2 + 8*4 + 2], 1'(k == 2));
          end
        end
      end
    end
  endtask

  task automatic test_stop2();
    int e, highs;
    exp_words.delete();
    exp_words.push_back(32'hFF);
    fork
      drive_words(3);
      record(3, 2 + 44 + 4);
    join
    e = wave_errs(4, 8, 0, 2, 2);
    checks++; if (e !== 0) begin errors++; $display("FAIL stop2_wave: %0d cycles differ, expected 0", e); end
    checks++; if (rec_done[2 + 44] !== 1'b1 || done_total() !== 1) begin
      errors++; $display("FAIL stop2_done: at44=%b count=%0d expected 1/1", rec_done[2 + 44], done_total());
    end
    highs = 0;
    for (int j = 2 + 36; j < 2 + 44; j++) if (rec_tx[j] === 1'b1) highs++;
    checks++; if (highs !== 8) begin errors++; $display("FAIL stop2_tail_high: got %0d expected 8", highs); end
  endtask

  task automatic test_back_to_back();
    int e;
    logic [2:0] peak;
    peak = 3'd0;
    exp_words.delete();
    for (int i = 1; i <= 5; i++) exp_words.push_back(i);
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          start[4] = 1'b1;
          dat[4]   = 9'(i);
          checks++;
          if (rdy_w[4] !== 1'(i <= 5)) begin errors++; $display("FAIL b2b_rdy_edge%0d: got %b expected %b", i, rdy_w[4], 1'(i <= 5)); end
          if (cnt_w[4] > peak) peak = cnt_w[4];
          @(negedge clk);
        end
        start[4] = 1'b0;
        if (cnt_w[4] > peak) peak = cnt_w[4];
      end
      record(4, 2 + 200 + 4);
    join
    checks++; if (peak !== 3'd4) begin errors++; $display("FAIL b2b_peak_cnt: got %0d expected 4", peak); end
    e = wave_errs(4, 8, 0, 1, 2);
    checks++; if (e !== 0) begin errors++; $display("FAIL b2b_wave: %0d cycles differ, expected 0", e); end
    checks++; if (done_total() !== 5) begin errors++; $display("FAIL b2b_done_count: got %0d expected 5", done_total()); end
    for (int f = 1; f <= 5; f++) begin
      checks++;
      if (rec_done[2 + 40*f] !== 1'b1) begin errors++; $display("FAIL b2b_done%0d: got %b expected 1", f, rec_done[2 + 40*f]); end
    end
  endtask

  task automatic test_reset_mid();
    int e;
    start[4] = 1'b1;
    dat[4]   = 9'($urandom_range(0, 255));
    @(negedge clk);
    dat[4]   = 9'($urandom_range(0, 255));
    @(negedge clk);
    start[4] = 1'b0;
    repeat (17) @(negedge clk);
    checks++; if (busy_w[4] !== 1'b1 || cnt_w[4] !== 3'd1) begin
      errors++; $display("FAIL mid_pre: busy=%b cnt=%0d expected 1/1", busy_w[4], cnt_w[4]);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_w[4] !== 1'b1) begin errors++; $display("FAIL mid_rst_tx: got %b expected 1", tx_w[4]); end
    checks++; if (busy_w[4] !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy_w[4]); end
    checks++; if (cnt_w[4] !== 3'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", cnt_w[4]); end
    checks++; if (rdy_w[4] !== 1'b1) begin errors++; $display("FAIL mid_rst_rdy: got %b expected 1", rdy_w[4]); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_words.delete();
    exp_words.push_back(32'h3C);
    fork
      drive_words(4);
      record(4, 2 + 40 + 8);
    join
    e = wave_errs(4, 8, 0, 1, 2);
    checks++; if (e !== 0) begin errors++; $display("FAIL mid_after_wave: %0d cycles differ, expected 0", e); end
    checks++; if (done_total() !== 1 || rec_done[2 + 40] !== 1'b1) begin
      errors++; $display("FAIL mid_after_done: count=%0d at40=%b expected 1/1", done_total(), rec_done[2 + 40]);
    end
  endtask

  task automatic test_random();
    int e;
    for (int r = 0; r < 3; r++) begin
      exp_words.delete();
      for (int i = 0; i < 4; i++) exp_words.push_back($urandom_range(0, 255));
      fork
        drive_words(4);
        record(4, 2 + 160 + 4);
      join
      e = wave_errs(4, 8, 0, 1, 2);
      checks++; if (e !== 0) begin errors++; $display("FAIL rand%0d_wave: %0d cycles differ, expected 0", r, e); end
      checks++; if (done_total() !== 4) begin errors++; $display("FAIL rand%0d_done_count: got %0d expected 4", r, done_total()); end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      start[k] = 1'b0;
      dat[k]   = '0;
    end
    test_reset();
    test_default();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
